// File: rtl/warp_ibuffer_pkg.sv
// Shared types and sizing for the per-warp instruction buffer.
package warp_ibuffer_pkg;

    localparam int NUM_WARPS   = 4;
    localparam int NW_WIDTH    = 2;
    localparam int NUM_THREADS = 4;
    localparam int PC_BITS     = 32;
    localparam int UUID_WIDTH  = 8;
    localparam int IBUF_SIZE   = 4;
    localparam int IBUF_CTR_W  = $clog2(IBUF_SIZE) + 1;

    // One queued instruction as it travels from fetch to issue.
    typedef struct packed {
        logic [UUID_WIDTH-1:0]  uuid;
        logic [PC_BITS-1:0]     pc;
        logic [NUM_THREADS-1:0] tmask;
        logic [31:0]            instr;
    } ibuf_entry_t;

    // Round-robin pick: first requester strictly after 'last', scanning
    // upward and wrapping. Relies on NUM_WARPS == 2**NW_WIDTH so the index
    // addition wraps naturally. Returns 'last' when nothing requests.
    function automatic logic [NW_WIDTH-1:0] rr_grant(
        input logic [NUM_WARPS-1:0] req,
        input logic [NW_WIDTH-1:0]  last
    );
        logic [NW_WIDTH-1:0] idx;
        logic                found;
        rr_grant = last;
        found    = 1'b0;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            idx = last + NW_WIDTH'(i);
            if (!found && req[idx]) begin
                rr_grant = idx;
                found    = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/warp_ibuffer_fifo.sv
// Single-warp instruction FIFO: distributed storage with asynchronous head
// read so the arbiter can look at the head in the same cycle it grants.
module warp_ibuffer_fifo
    import warp_ibuffer_pkg::*;
#(
    parameter string INSTANCE_ID = "",
    parameter int    SIZE        = IBUF_SIZE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  ibuf_entry_t data_in,
    output ibuf_entry_t data_out,
    output logic        empty,
    output logic        full
);

    localparam int AW = $clog2(SIZE);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    ibuf_entry_t mem [SIZE];

    // Pointer and occupancy update; a simultaneous push and pop leaves the
    // count alone while both pointers move.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers, cleared on reset so queued entries vanish.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write port; contents need no reset because occupancy gates use.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    assign data_out = mem[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(SIZE));

    a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(push && full))
        else $error("%s: push into full warp fifo", INSTANCE_ID);

    a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) !(pop && empty))
        else $error("%s: pop from empty warp fifo", INSTANCE_ID);

endmodule

// File: rtl/warp_ibuffer.sv
// Per-warp instruction buffer between fetch and issue: one FIFO per warp,
// round-robin selection into a single registered output slot, and a
// per-warp pop pulse so fetch can bound its outstanding requests.
module warp_ibuffer
    import warp_ibuffer_pkg::*;
#(
    parameter string INSTANCE_ID = "",
    parameter int    SIZE        = IBUF_SIZE
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   fetch_valid,
    output logic                   fetch_ready,
    input  logic [NW_WIDTH-1:0]    fetch_wid,
    input  logic [PC_BITS-1:0]     fetch_PC,
    input  logic [NUM_THREADS-1:0] fetch_tmask,
    input  logic [31:0]            fetch_instr,
    input  logic [UUID_WIDTH-1:0]  fetch_uuid,

    output logic                   ibuf_valid,
    input  logic                   ibuf_ready,
    output logic [NW_WIDTH-1:0]    ibuf_wid,
    output logic [PC_BITS-1:0]     ibuf_PC,
    output logic [NUM_THREADS-1:0] ibuf_tmask,
    output logic [31:0]            ibuf_instr,
    output logic [UUID_WIDTH-1:0]  ibuf_uuid,
    output logic [NUM_WARPS-1:0]   ibuf_pop
);

    ibuf_entry_t              fetch_entry;
    ibuf_entry_t              head [NUM_WARPS];
    logic [NUM_WARPS-1:0]     empty_vec;
    logic [NUM_WARPS-1:0]     full_vec;
    logic [NUM_WARPS-1:0]     push_vec;
    logic [NUM_WARPS-1:0]     pop_vec;
    logic [NUM_WARPS-1:0]     req;
    logic [NW_WIDTH-1:0]      grant;
    logic                     fetch_fire;
    logic                     load;

    logic                     ibuf_valid_q, ibuf_valid_d;
    ibuf_entry_t              out_entry_q,  out_entry_d;
    logic [NW_WIDTH-1:0]      out_wid_q,    out_wid_d;
    logic [NW_WIDTH-1:0]      last_grant_q, last_grant_d;
    logic [NUM_WARPS-1:0]     pop_pend_q,   pop_pend_d;
    logic [NUM_WARPS-1:0]     ibuf_pop_q,   ibuf_pop_d;

    assign fetch_entry = '{uuid:  fetch_uuid,
                           pc:    fetch_PC,
                           tmask: fetch_tmask,
                           instr: fetch_instr};

    // Readiness comes from registered occupancy only, so a pop in the same
    // cycle never frees the slot early.
    assign fetch_ready = ~full_vec[fetch_wid];
    assign fetch_fire  = fetch_valid && fetch_ready;

    assign req   = ~empty_vec;
    assign grant = rr_grant(req, last_grant_q);
    assign load  = (~ibuf_valid_q || ibuf_ready) && (|req);

    // Steer fetch pushes and arbiter pops to the addressed warp FIFO.
    always_comb begin
        push_vec = '0;
        pop_vec  = '0;
        if (fetch_fire) begin
            push_vec[fetch_wid] = 1'b1;
        end
        if (load) begin
            pop_vec[grant] = 1'b1;
        end
    end

    for (genvar w = 0; w < NUM_WARPS; w++) begin : gen_fifo
        warp_ibuffer_fifo #(
            .INSTANCE_ID (INSTANCE_ID),
            .SIZE        (SIZE)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .push     (push_vec[w]),
            .pop      (pop_vec[w]),
            .data_in  (fetch_entry),
            .data_out (head[w]),
            .empty    (empty_vec[w]),
            .full     (full_vec[w])
        );
    end

    // Output slot next state: load the granted head when the slot is free or
    // being consumed, otherwise drop valid once consumed, otherwise hold.
    // The pop pulse is staged so it appears the cycle after the entry first
    // shows up on the output.
    always_comb begin
        ibuf_valid_d = ibuf_valid_q;
        out_entry_d  = out_entry_q;
        out_wid_d    = out_wid_q;
        last_grant_d = last_grant_q;
        pop_pend_d   = '0;
        ibuf_pop_d   = pop_pend_q;
        if (load) begin
            ibuf_valid_d      = 1'b1;
            out_entry_d       = head[grant];
            out_wid_d         = grant;
            last_grant_d      = grant;
            pop_pend_d[grant] = 1'b1;
        end else if (ibuf_ready) begin
            ibuf_valid_d = 1'b0;
        end
    end

    // Control registers of the output stage; reset discards the slot and
    // any pop pulse still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            ibuf_valid_q <= 1'b0;
            last_grant_q <= NW_WIDTH'(NUM_WARPS - 1);
            pop_pend_q   <= '0;
            ibuf_pop_q   <= '0;
        end else begin
            ibuf_valid_q <= ibuf_valid_d;
            last_grant_q <= last_grant_d;
            pop_pend_q   <= pop_pend_d;
            ibuf_pop_q   <= ibuf_pop_d;
        end
    end

    // Output data registers; their contents only matter while valid is set.
    always_ff @(posedge clk) begin
        out_entry_q <= out_entry_d;
        out_wid_q   <= out_wid_d;
    end

    assign ibuf_valid = ibuf_valid_q;
    assign ibuf_wid   = out_wid_q;
    assign ibuf_PC    = out_entry_q.pc;
    assign ibuf_tmask = out_entry_q.tmask;
    assign ibuf_instr = out_entry_q.instr;
    assign ibuf_uuid  = out_entry_q.uuid;
    assign ibuf_pop   = ibuf_pop_q;

    a_pc_nonzero: assert property (@(posedge clk) disable iff (reset)
            fetch_fire |-> (fetch_PC != '0))
        else $error("%s: push with zero PC", INSTANCE_ID);

endmodule
